// File: rtl/compare_alarm_tracker_if.sv
// Comparator flag bundle and alarm/status outputs
// between the comparator and the status logic.
interface compare_alarm_tracker_if #(
    parameter int CW = 16
);
    logic          in_valid;
    logic          lesser;
    logic          greater;
    logic          equal;
    logic          clr;
    logic          alarm;
    logic          rise_pulse;
    logic          fall_pulse;
    logic [CW-1:0] gt_count;
    logic          gt_sat;
    logic          flag_err;

    modport master (
        output in_valid, lesser, greater, equal, clr,
        input  alarm, rise_pulse, fall_pulse,
        input  gt_count, gt_sat, flag_err
    );

    modport slave (
        input  in_valid, lesser, greater, equal, clr,
        output alarm, rise_pulse, fall_pulse,
        output gt_count, gt_sat, flag_err
    );
endinterface

// File: rtl/compare_alarm_tracker.sv
// Hysteresis alarm over comparator result flags,
// with saturating greater-event count and sticky flag error.
module compare_alarm_tracker #(
    parameter int SET_COUNT = 4,
    parameter int CLR_COUNT = 4,
    parameter int CW        = 16
) (
    input  logic clk,
    input  logic rst_n,
    compare_alarm_tracker_if.slave bus
);
    typedef enum logic [1:0] {
        LOW,
        ARMING,
        HIGH,
        DISARMING
    } state_t;

    localparam logic [7:0]    SET_C  = 8'(SET_COUNT);
    localparam logic [7:0]    CLR_C  = 8'(CLR_COUNT);
    localparam logic [CW-1:0] GT_MAX = '1;

    state_t        r_state;
    logic [7:0]    r_run;
    logic          r_alarm;
    logic          r_rise;
    logic          r_fall;
    logic [CW-1:0] r_gt_count;
    logic          r_gt_sat;
    logic          r_flag_err;

    state_t        w_state_nxt;
    logic [7:0]    w_run_nxt;
    logic [7:0]    w_run_inc;
    logic          w_onehot;
    logic          w_legal;
    logic          w_illegal;
    logic          w_gt_inc;
    logic          w_alarm_nxt;

    // Qualify the sample: exactly one flag set under in_valid
    always_comb begin
        w_onehot = 1'b0;
        unique case ({bus.lesser, bus.greater, bus.equal})
            3'b100, 3'b010, 3'b001: w_onehot = 1'b1;
            default:                w_onehot = 1'b0;
        endcase
        w_legal   = bus.in_valid & w_onehot;
        w_illegal = bus.in_valid & ~w_onehot;
        w_gt_inc  = w_legal & bus.greater;
        w_run_inc = r_run + 8'd1;
    end

    // Hysteresis next-state and run counter; idle/illegal hold
    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        if (w_legal) begin
            unique case (r_state)
                LOW: begin
                    if (bus.greater) begin
                        if (SET_C == 8'd1) begin
                            w_state_nxt = HIGH;
                            w_run_nxt   = 8'd0;
                        end else begin
                            w_state_nxt = ARMING;
                            w_run_nxt   = 8'd1;
                        end
                    end else begin
                        w_run_nxt = 8'd0;
                    end
                end
                ARMING: begin
                    if (bus.greater) begin
                        if (w_run_inc == SET_C) begin
                            w_state_nxt = HIGH;
                            w_run_nxt   = 8'd0;
                        end else begin
                            w_run_nxt = w_run_inc;
                        end
                    end else begin
                        w_state_nxt = LOW;
                        w_run_nxt   = 8'd0;
                    end
                end
                HIGH: begin
                    if (bus.lesser) begin
                        if (CLR_C == 8'd1) begin
                            w_state_nxt = LOW;
                            w_run_nxt   = 8'd0;
                        end else begin
                            w_state_nxt = DISARMING;
                            w_run_nxt   = 8'd1;
                        end
                    end else begin
                        w_run_nxt = 8'd0;
                    end
                end
                DISARMING: begin
                    if (bus.lesser) begin
                        if (w_run_inc == CLR_C) begin
                            w_state_nxt = LOW;
                            w_run_nxt   = 8'd0;
                        end else begin
                            w_run_nxt = w_run_inc;
                        end
                    end else begin
                        w_state_nxt = HIGH;
                        w_run_nxt   = 8'd0;
                    end
                end
                default: begin
                    w_state_nxt = LOW;
                    w_run_nxt   = 8'd0;
                end
            endcase
        end
        w_alarm_nxt = (w_state_nxt == HIGH) ||
                      (w_state_nxt == DISARMING);
    end

    // State, alarm level and edge pulses; clr drops the sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LOW;
            r_run   <= 8'd0;
            r_alarm <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else if (bus.clr) begin
            r_state <= LOW;
            r_run   <= 8'd0;
            r_alarm <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= w_run_nxt;
            r_alarm <= w_alarm_nxt;
            r_rise  <= w_alarm_nxt & ~r_alarm;
            r_fall  <= ~w_alarm_nxt & r_alarm;
        end
    end

    // Saturating greater counter and sticky status bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gt_count <= '0;
            r_gt_sat   <= 1'b0;
            r_flag_err <= 1'b0;
        end else if (bus.clr) begin
            r_gt_count <= '0;
            r_gt_sat   <= 1'b0;
            r_flag_err <= 1'b0;
        end else begin
            if (w_gt_inc && r_gt_count != GT_MAX) begin
                r_gt_count <= r_gt_count + CW'(1);
            end
            if (w_gt_inc && r_gt_count == GT_MAX - CW'(1)) begin
                r_gt_sat <= 1'b1;
            end
            if (w_illegal) begin
                r_flag_err <= 1'b1;
            end
        end
    end

    assign bus.alarm      = r_alarm;
    assign bus.rise_pulse = r_rise;
    assign bus.fall_pulse = r_fall;
    assign bus.gt_count   = r_gt_count;
    assign bus.gt_sat     = r_gt_sat;
    assign bus.flag_err   = r_flag_err;
endmodule

// File: tb/tb_compare_alarm_tracker.sv
// Directed bench for compare_alarm_tracker: a CW=16 instance
// and a CW=4 instance share one stimulus stream.
module tb_compare_alarm_tracker;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    compare_alarm_tracker_if #(.CW(16)) bus ();
    compare_alarm_tracker_if #(.CW(4))  sbus ();

    compare_alarm_tracker #(
        .SET_COUNT(4), .CLR_COUNT(4), .CW(16)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    compare_alarm_tracker #(
        .SET_COUNT(4), .CLR_COUNT(4), .CW(4)
    ) u_sat (
        .clk(clk), .rst_n(rst_n), .bus(sbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one sample at the falling edge, return #1 after the rising edge
    task automatic step(input logic v, input logic l, input logic g,
                        input logic e, input logic c);
        @(negedge clk);
        bus.in_valid  = v;  sbus.in_valid = v;
        bus.lesser    = l;  sbus.lesser   = l;
        bus.greater   = g;  sbus.greater  = g;
        bus.equal     = e;  sbus.equal    = e;
        bus.clr       = c;  sbus.clr      = c;
        @(posedge clk);
        #1;
    endtask

    task automatic gt();   step(1, 0, 1, 0, 0); endtask
    task automatic lt();   step(1, 1, 0, 0, 0); endtask
    task automatic eq();   step(1, 0, 0, 1, 0); endtask
    task automatic idle(); step(0, 0, 0, 0, 0); endtask
    task automatic clear(); step(0, 0, 0, 0, 1); endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_alarm"}, 32'(bus.alarm), 0);
        check({tag, "_rise"},  32'(bus.rise_pulse), 0);
        check({tag, "_fall"},  32'(bus.fall_pulse), 0);
        check({tag, "_cnt"},   32'(bus.gt_count), 0);
        check({tag, "_sat"},   32'(bus.gt_sat), 0);
        check({tag, "_err"},   32'(bus.flag_err), 0);
        check({tag, "_scnt"},  32'(sbus.gt_count), 0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus.in_valid = 0;  sbus.in_valid = 0;
        bus.lesser   = 0;  sbus.lesser   = 0;
        bus.greater  = 0;  sbus.greater  = 0;
        bus.equal    = 0;  sbus.equal    = 0;
        bus.clr      = 0;  sbus.clr      = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Four greaters raise the alarm on the fourth edge
        for (int i = 0; i < 3; i++) begin
            gt();
            check($sformatf("arm_alarm%0d", i), 32'(bus.alarm), 0);
            check($sformatf("arm_rise%0d", i), 32'(bus.rise_pulse), 0);
        end
        gt();
        check("raise_alarm", 32'(bus.alarm), 1);
        check("raise_rise", 32'(bus.rise_pulse), 1);
        check("raise_cnt", 32'(bus.gt_count), 4);
        check("raise_scnt", 32'(sbus.gt_count), 4);
        idle();
        check("rise_once", 32'(bus.rise_pulse), 0);
        check("hold_alarm", 32'(bus.alarm), 1);

        // Equal while HIGH keeps the alarm
        eq();
        check("eq_high", 32'(bus.alarm), 1);

        // Lesser run survives idle gaps; fall on the fourth lesser
        lt();
        check("dis1_alarm", 32'(bus.alarm), 1);
        lt();
        check("dis2_fall", 32'(bus.fall_pulse), 0);
        for (int i = 0; i < 5; i++) begin
            idle();
            check($sformatf("gap_alarm%0d", i), 32'(bus.alarm), 1);
            check($sformatf("gap_fall%0d", i), 32'(bus.fall_pulse), 0);
        end
        lt();
        check("dis3_alarm", 32'(bus.alarm), 1);
        check("dis3_fall", 32'(bus.fall_pulse), 0);
        lt();
        check("drop_alarm", 32'(bus.alarm), 0);
        check("drop_fall", 32'(bus.fall_pulse), 1);
        check("drop_rise", 32'(bus.rise_pulse), 0);
        idle();
        check("fall_once", 32'(bus.fall_pulse), 0);
        check("low_cnt", 32'(bus.gt_count), 4);

        clear();
        check_reset_state("clr1");

        // Equal breaks a greater run
        for (int i = 0; i < 3; i++) gt();
        eq();
        for (int i = 0; i < 3; i++) begin
            gt();
            check($sformatf("broken_alarm%0d", i), 32'(bus.alarm), 0);
        end
        check("broken_cnt", 32'(bus.gt_count), 6);
        gt();
        check("rerun_alarm", 32'(bus.alarm), 1);
        check("rerun_cnt", 32'(bus.gt_count), 7);

        clear();
        check_reset_state("clr2");

        // Illegal flags set flag_err, leave run and count alone
        gt();
        gt();
        step(1, 1, 1, 0, 0);
        check("err_dual", 32'(bus.flag_err), 1);
        check("err_cnt", 32'(bus.gt_count), 2);
        check("err_alarm", 32'(bus.alarm), 0);
        step(1, 0, 0, 0, 0);
        check("err_none", 32'(bus.flag_err), 1);
        idle();
        check("err_sticky", 32'(bus.flag_err), 1);
        gt();
        check("err_run_held", 32'(bus.alarm), 0);
        gt();
        check("err_run_raise", 32'(bus.alarm), 1);
        check("err_cnt2", 32'(bus.gt_count), 4);
        step(1, 1, 1, 1, 0);
        check("err_high_alarm", 32'(bus.alarm), 1);
        check("err_high_cnt", 32'(bus.gt_count), 4);

        clear();
        check_reset_state("clr3");

        // Saturation of the CW=4 counter
        for (int i = 1; i <= 20; i++) begin
            gt();
            if (i == 14) begin
                check("sat14_cnt", 32'(sbus.gt_count), 14);
                check("sat14_flag", 32'(sbus.gt_sat), 0);
            end
            if (i == 15) begin
                check("sat15_cnt", 32'(sbus.gt_count), 15);
                check("sat15_flag", 32'(sbus.gt_sat), 1);
            end
        end
        check("sat20_cnt", 32'(sbus.gt_count), 15);
        check("sat20_flag", 32'(sbus.gt_sat), 1);
        check("wide20_cnt", 32'(bus.gt_count), 20);
        check("wide20_sat", 32'(bus.gt_sat), 0);
        check("pre_rst_alarm", 32'(bus.alarm), 1);

        // Asynchronous reset mid-cycle while alarm is high
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_alarm", 32'(bus.alarm), 0);
        check("async_fall", 32'(bus.fall_pulse), 0);
        check("async_cnt", 32'(bus.gt_count), 0);
        check("async_ssat", 32'(sbus.gt_sat), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // clr with greater while ARMING: sample dropped, back to LOW
        gt();
        gt();
        gt();
        step(1, 0, 1, 0, 1);
        check("clrg_cnt", 32'(bus.gt_count), 0);
        check("clrg_alarm", 32'(bus.alarm), 0);
        for (int i = 0; i < 3; i++) begin
            gt();
            check($sformatf("clrg_low%0d", i), 32'(bus.alarm), 0);
        end
        gt();
        check("clrg_raise", 32'(bus.alarm), 1);
        check("clrg_cnt4", 32'(bus.gt_count), 4);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
